// File: rtl/serdesphy_pma_seq.sv
// serdesphy_pma_seq: PMA power-up/down sequencer with PLL lock qualification, relock and sticky fault.
module serdesphy_pma_seq #(
  parameter int ISO_WAIT     = 16,
  parameter int RST_WAIT     = 16,
  parameter int LOCK_TIMEOUT = 4800,
  parameter int LOCK_STABLE  = 64,
  parameter int MAX_RELOCK   = 3
) (
  input  logic       clk_ref_24m_i,
  input  logic       rst_n_i,
  input  logic       seq_enable_i,
  input  logic       pll_bypass_en_i,
  input  logic       pll_lock_raw_i,
  input  logic       pll_vco_ok_i,
  input  logic       pll_cp_ok_i,
  output logic       analog_iso_n_o,
  output logic       analog_reset_n_o,
  output logic       pll_enable_o,
  output logic       pll_reset_n_o,
  output logic       pll_iso_n_o,
  output logic       serializer_enable_o,
  output logic       serializer_reset_n_o,
  output logic       deserializer_enable_o,
  output logic       deserializer_reset_n_o,
  output logic       phy_ready_o,
  output logic       seq_fault_o,
  output logic [1:0] relock_cnt_o,
  output logic [3:0] seq_state_o
);
  typedef enum logic [3:0] {
    S_OFF, S_ISO, S_ARST, S_PLLEN, S_PLLRST, S_WAIT, S_STAB, S_TXRX, S_READY, S_FAULT
  } state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  relock_q, relock_d;
  logic [2:0]  s1_q, s2_q;
  logic [10:0] out_q, out_d;
  logic        lock_s, all_ok, z;
  assign lock_s = s2_q[0];
  assign all_ok = &s2_q;
  assign z      = cnt_q == 16'd0;
  function automatic logic [15:0] dwell(state_t s);
    return s == S_ISO ? 16'(ISO_WAIT - 1) :
           (s == S_ARST || s == S_PLLEN || s == S_TXRX) ? 16'(RST_WAIT - 1) :
           s == S_WAIT ? 16'(LOCK_TIMEOUT - 1) :
           s == S_STAB ? 16'(LOCK_STABLE - 1) : 16'd0;
  endfunction
  always_comb begin
    state_d  = state_q;
    relock_d = relock_q;
    if (state_q != S_OFF && !seq_enable_i) begin
      state_d  = S_OFF;
      relock_d = 2'd0;
    end else begin
      case (state_q)
        S_OFF:    state_d = seq_enable_i ? S_ISO : S_OFF;
        S_ISO:    state_d = z ? S_ARST : S_ISO;
        S_ARST:   state_d = z ? S_PLLEN : S_ARST;
        S_PLLEN:  state_d = z ? S_PLLRST : S_PLLEN;
        S_PLLRST: state_d = pll_bypass_en_i ? S_TXRX : S_WAIT;
        S_WAIT:   state_d = all_ok ? S_STAB : z ? S_FAULT : S_WAIT;
        S_STAB:   state_d = !lock_s ? S_WAIT : z ? S_TXRX : S_STAB;
        S_TXRX:   state_d = z ? S_READY : S_TXRX;
        S_READY:
          if (!lock_s && !pll_bypass_en_i) begin
            state_d  = int'(relock_q) < MAX_RELOCK ? S_PLLEN : S_FAULT;
            relock_d = relock_q == 2'd3 ? 2'd3 : relock_q + 2'd1;
          end
        S_FAULT:  state_d = S_FAULT;
        default:  state_d = S_OFF;
      endcase
    end
    cnt_d = state_d != state_q ? dwell(state_d) : z ? 16'd0 : cnt_q - 16'd1;
  end
  // Bit order: iso, arst, pll_en, pll_rst, pll_iso, ser_en, ser_rst, des_en, des_rst, ready, fault
  always_comb begin
    out_d     = '0;
    out_d[10] = state_q >= S_ISO && state_q <= S_READY;
    out_d[9]  = state_q >= S_ARST && state_q <= S_READY;
    out_d[8]  = state_q >= S_PLLEN && state_q <= S_READY;
    out_d[7]  = state_q >= S_PLLRST && state_q <= S_READY;
    out_d[6]  = out_d[10];
    out_d[5]  = state_q == S_TXRX || state_q == S_READY;
    out_d[4]  = state_q == S_READY;
    out_d[3]  = out_d[5];
    out_d[2]  = out_d[4];
    out_d[1]  = out_d[4];
    out_d[0]  = state_q == S_FAULT;
  end
  always_ff @(posedge clk_ref_24m_i) begin
    if (!rst_n_i) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      relock_q <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      relock_q <= relock_d;
      s1_q     <= {pll_cp_ok_i, pll_vco_ok_i, pll_lock_raw_i};
      s2_q     <= s1_q;
      out_q    <= out_d;
    end
  end
  assign {analog_iso_n_o, analog_reset_n_o, pll_enable_o, pll_reset_n_o, pll_iso_n_o,
          serializer_enable_o, serializer_reset_n_o, deserializer_enable_o,
          deserializer_reset_n_o, phy_ready_o, seq_fault_o} = out_q;
  assign relock_cnt_o = relock_q;
  assign seq_state_o  = state_q;
endmodule
